// File: rtl/rs_bank_if.sv
// Dispatch, CDB snoop and issue signals of the rs_bank reservation station.
// The master side drives dispatch/CDB/issue-accept; the slave side is the bank.
interface rs_bank_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OPC_W = 7
);
  logic                   disp_valid;
  logic                   disp_ready;
  logic [OPC_W-1:0]       disp_opcode;
  logic [4:0]             disp_rd;
  logic [TAG_W-1:0]       disp_t1;
  logic [TAG_W-1:0]       disp_t2;
  logic [XLEN-1:0]        disp_v1;
  logic [XLEN-1:0]        disp_v2;
  logic [TAG_W-1:0]       disp_tag;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [XLEN-1:0]        cdb_val;
  logic                   iss_valid;
  logic                   iss_ready;
  logic [OPC_W-1:0]       iss_opcode;
  logic [4:0]             iss_rd;
  logic [TAG_W-1:0]       iss_tag;
  logic [XLEN-1:0]        iss_v1;
  logic [XLEN-1:0]        iss_v2;
  logic [$clog2(DEPTH):0] occupancy;

  modport master (
    output disp_valid, disp_opcode, disp_rd, disp_t1, disp_t2, disp_v1, disp_v2,
    output cdb_valid, cdb_tag, cdb_val, iss_ready,
    input  disp_ready, disp_tag, iss_valid, iss_opcode, iss_rd, iss_tag, iss_v1, iss_v2,
    input  occupancy
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_rd, disp_t1, disp_t2, disp_v1, disp_v2,
    input  cdb_valid, cdb_tag, cdb_val, iss_ready,
    output disp_ready, disp_tag, iss_valid, iss_opcode, iss_rd, iss_tag, iss_v1, iss_v2,
    output occupancy
  );
endinterface

// File: rtl/rs_bank.sv
// Multi-entry reservation station bank: CDB snooping, oldest-ready-first issue.
// Optional macro RS_CDB_ISSUE_BYPASS_EN lets a CDB broadcast make an entry issuable the same cycle.
module rs_bank #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TAG_BASE = 1,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned OPC_W    = 7
) (
  input logic     clk,
  input logic     rst_n,
  input logic     flush,
  rs_bank_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] TagBase = TAG_W'(TAG_BASE);
  typedef logic [IDX_W-1:0] idx_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OPC_W-1:0] opc_q [DEPTH], opc_d [DEPTH];
  logic [4:0]       rd_q  [DEPTH], rd_d  [DEPTH];
  logic [TAG_W-1:0] q1_q  [DEPTH], q1_d  [DEPTH];
  logic [TAG_W-1:0] q2_q  [DEPTH], q2_d  [DEPTH];
  logic [XLEN-1:0]  v1_q  [DEPTH], v1_d  [DEPTH];
  logic [XLEN-1:0]  v2_q  [DEPTH], v2_d  [DEPTH];
  idx_t             age_q [DEPTH], age_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             free_found, sel_found, iss_fire, disp_fire, cap1, cap2;
  idx_t             free_idx, sel_idx, sel_age;
  logic [DEPTH-1:0] match1, match2, rdy;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
    end
  end

  always_comb begin
    match1 = '0;
    match2 = '0;
    rdy    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match1[i] = bus.cdb_valid && (q1_q[i] != '0) && (q1_q[i] == bus.cdb_tag);
      match2[i] = bus.cdb_valid && (q2_q[i] != '0) && (q2_q[i] == bus.cdb_tag);
`ifdef RS_CDB_ISSUE_BYPASS_EN
      rdy[i] = valid_q[i] && ((q1_q[i] == '0) || match1[i]) && ((q2_q[i] == '0) || match2[i]);
`else
      rdy[i] = valid_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
`endif
    end
  end

  // Oldest ready entry is the one with the largest age.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rdy[i] && (!sel_found || (age_q[i] > sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = idx_t'(i);
        sel_age   = age_q[i];
      end
    end
  end

  always_comb begin
    bus.disp_ready = free_found;
    bus.disp_tag   = TagBase + TAG_W'(free_idx);
    bus.occupancy  = occ_q;
    bus.iss_valid  = sel_found;
    bus.iss_opcode = '0;
    bus.iss_rd     = '0;
    bus.iss_tag    = '0;
    bus.iss_v1     = '0;
    bus.iss_v2     = '0;
    if (sel_found) begin
      bus.iss_opcode = opc_q[sel_idx];
      bus.iss_rd     = rd_q[sel_idx];
      bus.iss_tag    = TagBase + TAG_W'(sel_idx);
`ifdef RS_CDB_ISSUE_BYPASS_EN
      bus.iss_v1     = (q1_q[sel_idx] != '0) ? bus.cdb_val : v1_q[sel_idx];
      bus.iss_v2     = (q2_q[sel_idx] != '0) ? bus.cdb_val : v2_q[sel_idx];
`else
      bus.iss_v1     = v1_q[sel_idx];
      bus.iss_v2     = v2_q[sel_idx];
`endif
    end
  end

  assign iss_fire  = sel_found && bus.iss_ready;
  assign disp_fire = bus.disp_valid && free_found;
  assign cap1      = (bus.disp_t1 != '0) && bus.cdb_valid && (bus.cdb_tag == bus.disp_t1);
  assign cap2      = (bus.disp_t2 != '0) && bus.cdb_valid && (bus.cdb_tag == bus.disp_t2);

  always_comb begin
    valid_d = valid_q;
    opc_d   = opc_q;
    rd_d    = rd_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    age_d   = age_q;
    occ_d   = occ_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (match1[i]) begin
          q1_d[i] = '0;
          v1_d[i] = bus.cdb_val;
        end
        if (match2[i]) begin
          q2_d[i] = '0;
          v2_d[i] = bus.cdb_val;
        end
        if (iss_fire && (idx_t'(i) == sel_idx)) begin
          valid_d[i] = 1'b0;
          age_d[i]   = '0;
        end else begin
          if (iss_fire && (age_q[i] > sel_age)) age_d[i] = age_d[i] - idx_t'(1);
          if (disp_fire) age_d[i] = age_d[i] + idx_t'(1);
        end
      end else if (disp_fire && (idx_t'(i) == free_idx)) begin
        valid_d[i] = 1'b1;
        opc_d[i]   = bus.disp_opcode;
        rd_d[i]    = bus.disp_rd;
        q1_d[i]    = cap1 ? '0 : bus.disp_t1;
        v1_d[i]    = cap1 ? bus.cdb_val : bus.disp_v1;
        q2_d[i]    = cap2 ? '0 : bus.disp_t2;
        v2_d[i]    = cap2 ? bus.cdb_val : bus.disp_v2;
        age_d[i]   = '0;
      end
    end
    if (disp_fire) occ_d = occ_d + OCC_W'(1);
    if (iss_fire)  occ_d = occ_d - OCC_W'(1);
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        opc_q[i] <= '0;
        rd_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      age_q   <= age_d;
    end
  end
endmodule
